tt_um_customalu: RTL and testbench
==================================

TT_UM_CUSTOMALU -- requirements
Module: tt_um_customalu

Interface
REQ-001 Parameters: none; the block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low (sampled on the rising edge of clk).
REQ-004 ena  input  1  design-select; SHALL be ignored (no functional effect).
REQ-005 ui_in  input  8  operands: ui_in[3:0] = A, ui_in[7:4] = B, both unsigned 4-bit.
REQ-006 uio_in  input  8  uio_in[3:0] = opcode; uio_in[7:4] SHALL be ignored.
REQ-007 uo_out  output  8  registered ALU result.
REQ-008 uio_out  output  8  SHALL be constant 8'h00.
REQ-009 uio_oe  output  8  SHALL be constant 8'h00 (all uio pins are inputs).

Function
REQ-010 Every rising clk edge with rst_n=1, uo_out SHALL load f(opcode, A, B) from the current inputs; latency is exactly 1 cycle, with no handshake and no busy state.
REQ-011 Unused uo_out bits in each opcode below SHALL be 0.
REQ-012 0000 ADD: uo_out = A+B, 5-bit zero-extended (range 0..30).
REQ-013 0001 SUB: uo_out = (A-B) mod 256, 8-bit two's complement (e.g. 2-7 = 8'hFB).
REQ-014 0010 MUL: uo_out = A*B, 8-bit unsigned (max 225).
REQ-015 0011 DIV: B!=0 -> uo_out[3:0] = A/B (truncated), uo_out[7:4] = A%B; B=0 -> uo_out = 8'hFF.
REQ-016 0100 ROL: uo_out[3:0] = {A[2:0],A[3]}.
REQ-017 0101 ROR: uo_out[3:0] = {A[0],A[3:1]}.
REQ-018 0110 PRIORITY ENCODE: uo_out[1:0] = index of highest set bit of A, uo_out[2] = valid (A!=0); A=0 -> uo_out = 8'h00.
REQ-019 0111 GRAY: uo_out[3:0] = A ^ (A>>1).
REQ-020 1000 MAJORITY: uo_out[0] = 1 iff the popcount of {B,A} is >=5; a 4-of-8 tie gives 0.
REQ-021 1001 PARITY: uo_out[0] = XOR of A[3:0] (1 when the ones count is odd).
REQ-022 1010 AND: uo_out[3:0] = A&B.
REQ-023 1011 OR: uo_out[3:0] = A|B.
REQ-024 1100 NOT: uo_out[3:0] = ~A.
REQ-025 1101 XOR: uo_out[3:0] = A^B.
REQ-026 1110 GT: uo_out[0] = (A>B), unsigned.
REQ-027 1111 EQ: uo_out[0] = (A==B).
REQ-028 The result logic SHALL be purely combinational from ui_in/uio_in into the single output register; no other state exists.
REQ-029 An opcode or operand change SHALL be reflected exactly one edge later; back-to-back changes every cycle SHALL each be honoured.

Reset
REQ-030 With rst_n=0 at a rising edge, uo_out SHALL become 8'h00 on that edge, regardless of the inputs.
REQ-031 While rst_n=0, uo_out SHALL hold 8'h00; reset has no asynchronous effect between edges.
REQ-032 The first edge with rst_n=1 SHALL load the normal result for the inputs present at that edge.
REQ-033 uio_out and uio_oe SHALL be 8'h00 at all times, including during reset.

Verification
REQ-034 Reset: rst_n=0 for 2 edges with ui_in=8'hFF, opcode 0010 -> uo_out=8'h00; release -> 8'hE1 after 1 edge.
REQ-035 Arithmetic:
- A=3, B=5, op 0000 -> 8'h08
- A=7, B=2, op 0001 -> 8'h05
- A=2, B=7, op 0001 -> 8'hFB
- A=4, B=3, op 0010 -> 8'h0C
REQ-036 Division:
- A=8, B=2, op 0011 -> 8'h04
- A=9, B=2, op 0011 -> 8'h14
- A=8, B=0, op 0011 -> 8'hFF
REQ-037 Bit ops on A:
- A=9, op 0100 -> 8'h03
- A=9, op 0101 -> 8'h0C
- A=4, op 0110 -> 8'h06
- A=0, op 0110 -> 8'h00
- A=7, op 0111 -> 8'h04
REQ-038 Logic and detectors:
- A=5, B=10, op 1000 -> 8'h00
- A=6, op 1001 -> 8'h00
- A=12, B=10: op 1010 -> 8'h08, op 1011 -> 8'h0E, op 1101 -> 8'h06
- A=5, op 1100 -> 8'h0A
REQ-039 Compare:
- A=7, B=5, op 1110 -> 8'h01
- A=7, B=7, op 1111 -> 8'h01
- A=5, B=7, op 1110 -> 8'h00
- Every result SHALL appear exactly 1 cycle after its inputs are applied.

Source files
------------

// File: rtl/tt_um_customalu.sv
// tt_um_customalu: 16-opcode 4-bit ALU with one registered 8-bit result.
// A = ui_in[3:0], B = ui_in[7:4], opcode = uio_in[3:0]. The result settles
// combinationally and is captured on every rising clk edge. The uio bus is
// tied off as inputs only.
module tt_um_customalu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Opcode encoding
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_ROL = 4'b0100;
  localparam logic [3:0] OP_ROR = 4'b0101;
  localparam logic [3:0] OP_PEN = 4'b0110;
  localparam logic [3:0] OP_GRY = 4'b0111;
  localparam logic [3:0] OP_MAJ = 4'b1000;
  localparam logic [3:0] OP_PAR = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_NOT = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;
  localparam logic [3:0] OP_GT  = 4'b1110;
  localparam logic [3:0] OP_EQ  = 4'b1111;

  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] opcode;

  assign op_a   = ui_in[3:0];
  assign op_b   = ui_in[7:4];
  assign opcode = uio_in[3:0];

  // ena and the upper uio inputs have no functional effect.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // ---------------------------------------------------------------------------
  // Per-operation datapaths, all evaluated in parallel and muxed by opcode.
  // ---------------------------------------------------------------------------
  logic [4:0] add_res;
  logic [7:0] sub_res;
  logic [7:0] mul_res;
  logic [7:0] div_res;
  logic [3:0] rol_res;
  logic [3:0] ror_res;
  logic [2:0] pen_res;
  logic [3:0] gray_res;
  logic       maj_res;
  logic       par_res;
  logic       gt_res;
  logic       eq_res;

  assign add_res = {1'b0, op_a} + {1'b0, op_b};
  assign sub_res = {4'h0, op_a} - {4'h0, op_b};
  assign mul_res = {4'h0, op_a} * {4'h0, op_b};
  assign rol_res = {op_a[2:0], op_a[3]};
  assign ror_res = {op_a[0], op_a[3:1]};
  assign par_res = ^op_a;
  assign gt_res  = (op_a > op_b);
  assign eq_res  = (op_a == op_b);

  // Gray code: each bit is the XOR with its upper neighbour; the MSB passes.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gray
      assign gray_res[gi] = op_a[gi] ^ op_a[gi+1];
    end
  endgenerate
  assign gray_res[3] = op_a[3];

  // Divider: quotient in the low nibble, remainder in the high nibble.
  // A zero divisor never reaches the divide operators and reports all ones.
  logic [3:0] quot;
  logic [3:0] rem;
  always_comb begin
    quot = 4'h0;
    rem  = 4'h0;
    if (op_b != 4'h0) begin
      quot = op_a / op_b;
      rem  = op_a % op_b;
    end
  end
  assign div_res = (op_b == 4'h0) ? 8'hFF : {rem, quot};

  // Priority encoder: index of the highest set bit of A, plus a valid flag.
  always_comb begin
    pen_res = 3'b000;
    if (op_a[3])      pen_res = 3'b111;
    else if (op_a[2]) pen_res = 3'b110;
    else if (op_a[1]) pen_res = 3'b101;
    else if (op_a[0]) pen_res = 3'b100;
  end

  // Majority over all eight operand bits; a 4-of-8 tie is not a majority.
  logic [7:0] maj_bits;
  logic [3:0] ones_cnt;
  assign maj_bits = {op_b, op_a};
  always_comb begin
    ones_cnt = 4'h0;
    for (int i = 0; i < 8; i++) begin
      ones_cnt = ones_cnt + {3'b000, maj_bits[i]};
    end
  end
  assign maj_res = (ones_cnt >= 4'd5);

  // ---------------------------------------------------------------------------
  // Result select; bits not driven by an operation stay zero.
  // ---------------------------------------------------------------------------
  logic [7:0] result_next;
  logic [7:0] result_reg;

  // Opcode mux feeding the output register.
  always_comb begin
    result_next = 8'h00;
    case (opcode)
      OP_ADD: result_next = {3'b000, add_res};
      OP_SUB: result_next = sub_res;
      OP_MUL: result_next = mul_res;
      OP_DIV: result_next = div_res;
      OP_ROL: result_next = {4'h0, rol_res};
      OP_ROR: result_next = {4'h0, ror_res};
      OP_PEN: result_next = {5'b00000, pen_res};
      OP_GRY: result_next = {4'h0, gray_res};
      OP_MAJ: result_next = {7'b0000000, maj_res};
      OP_PAR: result_next = {7'b0000000, par_res};
      OP_AND: result_next = {4'h0, op_a & op_b};
      OP_OR:  result_next = {4'h0, op_a | op_b};
      OP_NOT: result_next = {4'h0, ~op_a};
      OP_XOR: result_next = {4'h0, op_a ^ op_b};
      OP_GT:  result_next = {7'b0000000, gt_res};
      OP_EQ:  result_next = {7'b0000000, eq_res};
      default: result_next = 8'h00;
    endcase
  end

  // Output register: cleared by synchronous reset, otherwise loads every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_reg <= 8'h00;
    end else begin
      result_reg <= result_next;
    end
  end

  assign uo_out  = result_reg;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_customalu.sv
// Testbench for tt_um_customalu: directed vector table, reset sequences and
// random back-to-back traffic. Expected values go into a scoreboard queue when
// inputs are driven and are checked one clock edge later.
module tb_tt_um_customalu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_customalu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Independent reference model of the ALU.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
    int ia, ib, r, hi;
    ia = a;
    ib = b;
    r  = 0;
    case (op)
      4'd0:  r = ia + ib;
      4'd1:  r = (ia - ib + 256) % 256;
      4'd2:  r = ia * ib;
      4'd3:  r = (ib == 0) ? 255 : ((ia % ib) * 16 + ia / ib);
      4'd4:  r = ((ia * 2) % 16) + ia / 8;
      4'd5:  r = ia / 2 + (ia % 2) * 8;
      4'd6: begin
        hi = -1;
        for (int i = 0; i < 4; i++) if (a[i]) hi = i;
        r = (hi < 0) ? 0 : (4 + hi);
      end
      4'd7:  r = ia ^ (ia / 2);
      4'd8:  r = ($countones({b, a}) >= 5) ? 1 : 0;
      4'd9:  r = $countones(a) % 2;
      4'd10: r = ia & ib;
      4'd11: r = ia | ib;
      4'd12: r = 15 - ia;
      4'd13: r = ia ^ ib;
      4'd14: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return r[7:0];
  endfunction

  // Drive one transaction at the falling edge and queue its expected result.
  task automatic drive(input logic rst, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [7:0] exp, input string tag);
    sb_t e;
    @(negedge clk);
    rst_n  = rst;
    ui_in  = {b, a};
    uio_in = {4'($urandom_range(15)), op};
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Checker: one edge after each drive, compare the registered outputs.
  sb_t cur;
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_tests++;
      if (uo_out !== cur.exp) begin
        n_fail++;
        $display("FAIL %s: uo_out=%02h expected %02h", cur.tag, uo_out, cur.exp);
      end else begin
        $display("[TB] %s: uo_out=%02h ok", cur.tag, uo_out);
      end
      n_tests++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
        n_fail++;
        $display("FAIL %s_uio: uio_out=%02h uio_oe=%02h expected 00/00",
                 cur.tag, uio_out, uio_oe);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Directed vectors {A, B, opcode, expected}.
    vecs.push_back('{4'd3,  4'd5,  4'b0000, 8'h08});
    vecs.push_back('{4'd7,  4'd2,  4'b0001, 8'h05});
    vecs.push_back('{4'd2,  4'd7,  4'b0001, 8'hFB});
    vecs.push_back('{4'd4,  4'd3,  4'b0010, 8'h0C});
    vecs.push_back('{4'd8,  4'd2,  4'b0011, 8'h04});
    vecs.push_back('{4'd9,  4'd2,  4'b0011, 8'h14});
    vecs.push_back('{4'd8,  4'd0,  4'b0011, 8'hFF});
    vecs.push_back('{4'd9,  4'd0,  4'b0100, 8'h03});
    vecs.push_back('{4'd9,  4'd0,  4'b0101, 8'h0C});
    vecs.push_back('{4'd4,  4'd0,  4'b0110, 8'h06});
    vecs.push_back('{4'd0,  4'd0,  4'b0110, 8'h00});
    vecs.push_back('{4'd7,  4'd0,  4'b0111, 8'h04});
    vecs.push_back('{4'd5,  4'd10, 4'b1000, 8'h00});
    vecs.push_back('{4'd6,  4'd0,  4'b1001, 8'h00});
    vecs.push_back('{4'd12, 4'd10, 4'b1010, 8'h08});
    vecs.push_back('{4'd12, 4'd10, 4'b1011, 8'h0E});
    vecs.push_back('{4'd12, 4'd10, 4'b1101, 8'h06});
    vecs.push_back('{4'd5,  4'd0,  4'b1100, 8'h0A});
    vecs.push_back('{4'd7,  4'd5,  4'b1110, 8'h01});
    vecs.push_back('{4'd7,  4'd7,  4'b1111, 8'h01});
    vecs.push_back('{4'd5,  4'd7,  4'b1110, 8'h00});
    // Boundaries: widest sums/products, remainders, ties, odd parity.
    vecs.push_back('{4'd15, 4'd15, 4'b0000, 8'h1E});
    vecs.push_back('{4'd15, 4'd15, 4'b0010, 8'hE1});
    vecs.push_back('{4'd0,  4'd15, 4'b0001, 8'hF1});
    vecs.push_back('{4'd15, 4'd4,  4'b0011, 8'h33});
    vecs.push_back('{4'd3,  4'd7,  4'b0011, 8'h30});
    vecs.push_back('{4'd8,  4'd0,  4'b0110, 8'h07});
    vecs.push_back('{4'd1,  4'd0,  4'b0110, 8'h04});
    vecs.push_back('{4'd15, 4'd1,  4'b1000, 8'h01});
    vecs.push_back('{4'd15, 4'd0,  4'b1000, 8'h00});
    vecs.push_back('{4'd7,  4'd0,  4'b1001, 8'h01});
    vecs.push_back('{4'd7,  4'd7,  4'b1110, 8'h00});
    vecs.push_back('{4'd7,  4'd6,  4'b1111, 8'h00});
    vecs.push_back('{4'd8,  4'd0,  4'b0100, 8'h01});
    vecs.push_back('{4'd1,  4'd0,  4'b0101, 8'h08});

    // Reset held for two edges with live inputs, then released.
    drive(1'b0, 4'hF, 4'hF, 4'b0010, 8'h00, "rst_edge1");
    drive(1'b0, 4'hF, 4'hF, 4'b0010, 8'h00, "rst_edge2");
    drive(1'b1, 4'hF, 4'hF, 4'b0010, 8'hE1, "rst_release");

    // Directed table, back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp,
            $sformatf("vec%0d_op%0h", i, vecs[i].op));
    end

    // Random back-to-back traffic with ena toggling.
    for (int i = 0; i < 64; i++) begin
      logic [3:0] ra, rb, rop;
      ra  = 4'($urandom_range(15));
      rb  = 4'($urandom_range(15));
      rop = 4'($urandom_range(15));
      ena = 1'($urandom_range(1));
      drive(1'b1, ra, rb, rop, ref_alu(ra, rb, rop),
            $sformatf("rnd%0d_a%0h_b%0h_op%0h", i, ra, rb, rop));
    end
    ena = 1'b1;

    // Mid-stream reset, then the first edge out of reset loads normally.
    drive(1'b0, 4'd3, 4'd5, 4'b0000, 8'h00, "mid_rst");
    drive(1'b1, 4'd3, 4'd5, 4'b0000, 8'h08, "mid_release");
    drive(1'b1, 4'd2, 4'd7, 4'b0001, 8'hFB, "post_rst_sub");

    // Let the scoreboard drain (bounded).
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
